// File: rtl/encoders_decoder.sv
// Quadrature decoder for four rotary encoders plus eight buttons, with snapshot-and-clear readout.
// Optional feature: define ENCODERS_ERR_CNT_EN to build per-encoder invalid-transition counters.
module encoders_decoder #(
  parameter int STEPS_PER_DETENT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] debounced,
  input  logic        snap_req,
  output logic        snap_ack,
  output logic [31:0] delta,
  output logic [7:0]  buttons,
  output logic        changed,
  output logic [15:0] err_cnt
);

  localparam logic signed [3:0] STEP_POS = 4'(STEPS_PER_DETENT);
  localparam logic signed [3:0] STEP_NEG = 4'(-STEPS_PER_DETENT);

  // init_q marks the first cycle out of reset, where prev {B,A} is loaded without evaluation.
  logic              init_q, init_d;
  logic [1:0]        prev_q [4];
  logic [1:0]        prev_d [4];
  logic signed [2:0] sub_q  [4];
  logic signed [2:0] sub_d  [4];
  logic signed [7:0] acc_q  [4];
  logic signed [7:0] acc_d  [4];
  logic [31:0]       delta_q, delta_d;
  logic [7:0]        buttons_q, buttons_d;
  logic              snap_ack_q, snap_ack_d;
  logic              changed_q, changed_d;
`ifdef ENCODERS_ERR_CNT_EN
  logic [3:0]        err_q [4];
  logic [3:0]        err_d [4];
`endif

  always_comb begin
    logic [1:0]        cur;
    logic [1:0]        prv;
    logic              inv;
    logic signed [1:0] dir;
    logic signed [3:0] sum;
    logic signed [1:0] step;
    logic signed [7:0] base;
    logic signed [8:0] s9;
    logic              any_nz;

    cur        = '0;
    prv        = '0;
    inv        = 1'b0;
    dir        = '0;
    sum        = '0;
    step       = '0;
    base       = '0;
    s9         = '0;
    any_nz     = 1'b0;
    init_d     = 1'b0;
    delta_d    = delta_q;
    buttons_d  = buttons_q;
    snap_ack_d = snap_req;

    if (snap_req) begin
      buttons_d = debounced[15:8];
    end

    for (int i = 0; i < 4; i++) begin
      cur = debounced[2*i +: 2];
      prv = prev_q[i];
      inv = !init_q && ((cur ^ prv) == 2'b11);
      dir = '0;
      if (!init_q && !inv && (cur != prv)) begin
        case ({prv, cur})
          4'b0001, 4'b0111, 4'b1110, 4'b1000: dir = 2'sb01;
          default:                            dir = 2'sb11;
        endcase
      end
      prev_d[i] = cur;

      sum  = {sub_q[i][2], sub_q[i]} + {{2{dir[1]}}, dir};
      step = '0;
      if (sum == STEP_POS) begin
        sub_d[i] = '0;
        step     = 2'sb01;
      end else if (sum == STEP_NEG) begin
        sub_d[i] = '0;
        step     = 2'sb11;
      end else begin
        sub_d[i] = sum[2:0];
      end

      // A step on the snapshot edge lands in the freshly cleared accumulator.
      if (snap_req) begin
        delta_d[8*i +: 8] = acc_q[i];
      end
      base = snap_req ? 8'sd0 : acc_q[i];
      s9   = {base[7], base} + {{7{step[1]}}, step};
      if (s9[8] != s9[7]) begin
        acc_d[i] = s9[8] ? 8'sh80 : 8'sh7F;
      end else begin
        acc_d[i] = s9[7:0];
      end
      any_nz = any_nz | (acc_d[i] != 8'sd0);

`ifdef ENCODERS_ERR_CNT_EN
      err_d[i] = err_q[i];
      if (inv && (err_q[i] != 4'hF)) begin
        err_d[i] = err_q[i] + 4'd1;
      end
`endif
    end

    changed_d = any_nz | (debounced[15:8] != buttons_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      init_q     <= 1'b1;
      delta_q    <= '0;
      buttons_q  <= '0;
      snap_ack_q <= 1'b0;
      changed_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        prev_q[i] <= '0;
        sub_q[i]  <= '0;
        acc_q[i]  <= '0;
`ifdef ENCODERS_ERR_CNT_EN
        err_q[i]  <= '0;
`endif
      end
    end else begin
      init_q     <= init_d;
      delta_q    <= delta_d;
      buttons_q  <= buttons_d;
      snap_ack_q <= snap_ack_d;
      changed_q  <= changed_d;
      for (int i = 0; i < 4; i++) begin
        prev_q[i] <= prev_d[i];
        sub_q[i]  <= sub_d[i];
        acc_q[i]  <= acc_d[i];
`ifdef ENCODERS_ERR_CNT_EN
        err_q[i]  <= err_d[i];
`endif
      end
    end
  end

  assign snap_ack = snap_ack_q;
  assign delta    = delta_q;
  assign buttons  = buttons_q;
  assign changed  = changed_q;
`ifdef ENCODERS_ERR_CNT_EN
  assign err_cnt  = {err_q[3], err_q[2], err_q[1], err_q[0]};
`else
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_encoders_decoder.sv
// Bench for encoders_decoder: vector table of detent runs plus hand-written snapshot corner cases.
module tb_encoders_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] debounced;
  logic        snap_req;
  logic        snap_ack;
  logic [31:0] delta;
  logic [7:0]  buttons;
  logic        changed;
  logic [15:0] err_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [39:0] exp_q[$];
  logic [1:0]  ab_state [4];

  typedef struct {
    int          enc;
    int          detents;
    int          hold;
    logic [7:0]  btn;
    logic [31:0] exp_delta;
    logic        exp_changed;
  } vec_t;

  vec_t vecs [7];

  encoders_decoder #(.STEPS_PER_DETENT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .debounced (debounced),
    .snap_req  (snap_req),
    .snap_ack  (snap_ack),
    .delta     (delta),
    .buttons   (buttons),
    .changed   (changed),
    .err_cnt   (err_cnt)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- helpers ----
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] gray_cw(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] gray_ccw(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic set_ab(input int enc, input logic [1:0] ab, input int hold);
    ab_state[enc] = ab;
    debounced[2*enc +: 2] = ab;
    repeat (hold) tick();
  endtask

  task automatic apply_detents(input int enc, input int n, input int hold);
    int cnt;
    cnt = (n < 0) ? -n : n;
    for (int d = 0; d < cnt; d++) begin
      for (int t = 0; t < 4; t++) begin
        set_ab(enc, (n > 0) ? gray_cw(ab_state[enc]) : gray_ccw(ab_state[enc]), hold);
      end
    end
  endtask

  // One-cycle request; the monitor compares the snapshot when the ack shows up.
  task automatic do_snap(input logic [31:0] exp_delta, input logic [7:0] exp_btn,
                         input logic exp_changed);
    exp_q.push_back({exp_delta, exp_btn});
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    check("snap_ack_high", {31'd0, snap_ack}, 32'd1);
    check("changed_in_ack", {31'd0, changed}, {31'd0, exp_changed});
    tick();
    check("snap_ack_pulse", {31'd0, snap_ack}, 32'd0);
  endtask

  // ---- scoreboard monitor ----
  always @(negedge clk) begin
    if (snap_ack) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ack: delta %h buttons %h with no request outstanding at %0t",
                 delta, buttons, $time);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("snap_delta", delta, e[39:8]);
        check("snap_buttons", {24'd0, buttons}, {24'd0, e[7:0]});
      end
    end
  end

  // ---- stimulus ----
  initial begin
    logic [15:0] exp_err;
`ifdef ENCODERS_ERR_CNT_EN
    exp_err = 16'h2000;
`else
    exp_err = 16'h0000;
`endif
    vecs[0] = '{enc: 0, detents:    1, hold: 4, btn: 8'h00, exp_delta: 32'h0000_0001, exp_changed: 1'b1};
    vecs[1] = '{enc: 2, detents:   -3, hold: 1, btn: 8'h00, exp_delta: 32'h00FD_0000, exp_changed: 1'b1};
    vecs[2] = '{enc: 1, detents:  200, hold: 1, btn: 8'h00, exp_delta: 32'h0000_7F00, exp_changed: 1'b1};
    vecs[3] = '{enc: 1, detents: -200, hold: 1, btn: 8'h00, exp_delta: 32'h0000_8000, exp_changed: 1'b1};
    vecs[4] = '{enc: 3, detents:    2, hold: 2, btn: 8'h81, exp_delta: 32'h0200_0000, exp_changed: 1'b1};
    vecs[5] = '{enc: 0, detents:   -5, hold: 1, btn: 8'h81, exp_delta: 32'h0000_00FB, exp_changed: 1'b1};
    vecs[6] = '{enc: 0, detents:    0, hold: 1, btn: 8'h81, exp_delta: 32'h0000_0000, exp_changed: 1'b0};

    for (int i = 0; i < 4; i++) ab_state[i] = 2'b00;
    reset     = 1'b1;
    debounced = 16'h0000;
    snap_req  = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_delta", delta, 32'd0);
    check("rst_buttons", {24'd0, buttons}, 32'd0);
    check("rst_snap_ack", {31'd0, snap_ack}, 32'd0);
    check("rst_changed", {31'd0, changed}, 32'd0);
    check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);

    for (int v = 0; v < 7; v++) begin
      debounced[15:8] = vecs[v].btn;
      apply_detents(vecs[v].enc, vecs[v].detents, vecs[v].hold);
      tick();
      check("changed_before_snap", {31'd0, changed}, {31'd0, vecs[v].exp_changed});
      do_snap(vecs[v].exp_delta, vecs[v].btn, 1'b0);
    end

    // Detent completes on the snapshot edge: excluded now, reported next time.
    set_ab(0, 2'b01, 1);
    set_ab(0, 2'b11, 1);
    set_ab(0, 2'b10, 1);
    ab_state[0] = 2'b00;
    debounced[1:0] = 2'b00;
    do_snap(32'h0000_0000, 8'h81, 1'b1);
    do_snap(32'h0000_0001, 8'h81, 1'b0);

    // Back-to-back requests give two acks.
    apply_detents(2, 1, 1);
    tick();
    exp_q.push_back({32'h0001_0000, 8'h81});
    exp_q.push_back({32'h0000_0000, 8'h81});
    snap_req = 1'b1;
    tick();
    check("b2b_ack1", {31'd0, snap_ack}, 32'd1);
    tick();
    snap_req = 1'b0;
    check("b2b_ack2", {31'd0, snap_ack}, 32'd1);
    tick();
    check("b2b_ack_end", {31'd0, snap_ack}, 32'd0);

    // Invalid double-bit transitions on enc3, net valid motion zero.
    set_ab(3, 2'b11, 2);
    set_ab(3, 2'b10, 2);
    set_ab(3, 2'b00, 2);
    set_ab(3, 2'b11, 2);
    set_ab(3, 2'b01, 2);
    set_ab(3, 2'b00, 2);
    check("err_cnt", {16'd0, err_cnt}, {16'd0, exp_err});
    check("err_no_change", {31'd0, changed}, 32'd0);
    do_snap(32'h0000_0000, 8'h81, 1'b0);

    // Reset on the request edge aborts the snapshot.
    apply_detents(0, 1, 1);
    reset    = 1'b1;
    snap_req = 1'b1;
    tick();
    reset    = 1'b0;
    snap_req = 1'b0;
    check("abort_ack0", {31'd0, snap_ack}, 32'd0);
    tick();
    check("abort_ack1", {31'd0, snap_ack}, 32'd0);
    check("abort_delta", delta, 32'd0);
    check("abort_err_cnt", {16'd0, err_cnt}, 32'd0);

    // Encoder held at 11 across reset release must not count; then press button 5.
    reset     = 1'b1;
    debounced = 16'h0003;
    for (int i = 0; i < 4; i++) ab_state[i] = 2'b00;
    ab_state[0] = 2'b11;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    check("release_changed", {31'd0, changed}, 32'd0);
    debounced = 16'h2003;
    tick();
    check("button_changed", {31'd0, changed}, 32'd1);
    do_snap(32'h0000_0000, 8'h20, 1'b0);
    check("buttons_hold", {24'd0, buttons}, 32'h20);

    repeat (2) tick();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/encoders_decoder.md
ENCODERS_DECODER -- requirements
Module: encoders_decoder

Interface
REQ-001 Parameter STEPS_PER_DETENT, default 4, means valid quadrature transitions per counted step; legal values are 1, 2 and 4.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 debounced  input  16  debounced pin vector from the scanner; bits [2i+1:2i] = {B,A} of encoder i (i=0..3), bits [15:8] = buttons 0..7, 1=pressed.
REQ-005 snap_req  input  1  one-cycle request to snapshot and clear the accumulators.
REQ-006 snap_ack  output  1  one-cycle pulse, snapshot outputs valid.
REQ-007 delta  output  32  snapshot; [8i+7:8i] = signed two's-complement step count of encoder i since the previous snapshot.
REQ-008 buttons  output  8  snapshot of debounced[15:8].
REQ-009 changed  output  1  level; high while any live accumulator is nonzero or live buttons differ from the buttons output.
REQ-010 err_cnt  output  16  [4i+3:4i] = invalid-transition count of encoder i.

Function
REQ-011 Per encoder, the block SHALL register previous {B,A} and compare it with the current debounced value every cycle.
REQ-012 Gray sequence 00->01->11->10->00 SHALL be +1 transition; the reverse sequence SHALL be -1; no change SHALL be 0.
REQ-013 A transition changing both A and B SHALL be invalid: no count, previous {B,A} still updated.
REQ-014 Per encoder, a signed 3-bit sub-counter SHALL accumulate transitions; on reaching +STEPS_PER_DETENT it SHALL clear and emit a +1 step; on reaching -STEPS_PER_DETENT it SHALL clear and emit -1.
REQ-015 Direction reversal mid-detent SHALL decrement or increment the sub-counter toward zero with no step emitted.
REQ-016 The live accumulator per encoder SHALL be signed 8-bit, saturating at +127 and -128; no wrap-around.
REQ-017 Latency: an input change sampled on edge N SHALL be reflected in the live accumulator after edge N.
REQ-018 A snap_req sampled on edge N SHALL load delta from the live accumulators and buttons from debounced[15:8], then clear the accumulators; snap_ack SHALL be high in the cycle after edge N.
REQ-019 A step on the same edge as snap_req SHALL go into the cleared accumulator (value +-1); it SHALL NOT be included in the snapshot and SHALL NOT be lost.
REQ-020 A snap_req while snap_ack is high SHALL be honoured as a new snapshot; back-to-back requests each produce one ack.
REQ-021 delta and buttons SHALL hold between snapshots.
REQ-022 changed SHALL be registered, derived from post-edge state; it SHALL be low in the snap_ack cycle if no new activity occurred on the request edge.
REQ-023 Sub-counters SHALL NOT be cleared by a snapshot.

Reset
REQ-024 On reset, delta=0, buttons=0, snap_ack=0, changed=0, err_cnt=0, and sub-counters and accumulators SHALL be 0.
REQ-025 On the first cycle after reset release, previous {B,A} SHALL load from debounced with no transition evaluated; this prevents a spurious count.
REQ-026 Reset during a pending snapshot SHALL abort it; no snap_ack is issued.

Configuration
REQ-027 With ENCODERS_ERR_CNT_EN defined, each encoder SHALL have a 4-bit invalid-transition counter that saturates at 15, drives err_cnt, and clears only on reset.
REQ-028 Without ENCODERS_ERR_CNT_EN, err_cnt SHALL be constant 0 and no counter logic is built; all other behaviour is identical.

Verification
REQ-029 STEPS_PER_DETENT=4; apply enc0 AB 00,01,11,10,00 at 4 cycles each; then snap_req -> delta[7:0]=8'h01, snap_ack one cycle later, changed low afterward.
REQ-030 Apply the reverse sequence on enc2 three detents -> delta[23:16]=8'hFD; other lanes 0.
REQ-031 Apply 200 CW detents on enc1, then snap -> delta[15:8]=8'h7F; repeat with CCW -> 8'h80.
REQ-032 Complete a detent on the same edge as snap_req -> snapshot 0, next snapshot +1.
REQ-033 Apply enc3 AB 00->11 twice, with the macro defined -> err_cnt[15:12]=2 and delta unchanged; without the macro -> err_cnt=0.
REQ-034 Hold debounced=16'h0003 through reset release, then press button 5 (bit 13) -> no encoder count, changed=1, snap gives buttons=8'h20.
